pdp11_inst_encoder: RTL and testbench

Instruction encoder for the PDP-11/20 ISA simulator. It takes one symbolic instruction per handshake: a mnemonic, modes, registers, branch offset and operand extension words. It emits the matching 16-bit machine-code stream of 1–3 words on a valid/ready output. It feeds the memory loader and the bench's program generator, and produces words that the simulator's decode formats (double-op, branch, single-op, PSW, jump, swab, sys) parse back losslessly.

---
 rtl/pdp11_inst_encoder_pkg.sv | 73 +++++++
 rtl/pdp11_inst_encoder_if.sv | 42 ++++
 rtl/pdp11_opcode_rom.sv | 80 ++++++++
 rtl/pdp11_inst_encoder.sv | 145 ++++++++++++++
 tb/tb_pdp11_inst_encoder.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/pdp11_inst_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pdp11_inst_encoder_pkg
// Purpose  : Shared types, octal base opcodes and the extension-word rule
//            for the PDP-11/20 instruction encoder.
// Revision : 1.0 - initial release
// ============================================================================
package pdp11_inst_encoder_pkg;

    localparam int WORD_SIZE = 16;

    typedef logic [2:0] mode_t;
    typedef logic [2:0] reg_t;

    // Symbolic mnemonics; 65 entries, so values 65..127 are out of range
    typedef enum logic [6:0] {
        MOV, CMP, BIT, BIC, BIS, ADD, SUB,
        MOVB, CMPB, BITB, BICB, BISB,
        BR, BNE, BEQ, BGE, BLT, BGT, BLE,
        BPL, BMI, BHI, BLOS, BVC, BVS, BCC, BCS,
        CLR, COM, INC, DEC, NEG, ADC, SBC, TST, ROR, ROL, ASR, ASL,
        CLRB, COMB, INCB, DECB, NEGB, ADCB, SBCB, TSTB, RORB, ROLB, ASRB, ASLB,
        JSR, RTS, JMP, SWAB,
        HALT, NOP, CLC, CLV, CLZ, CLN, SEC, SEV, SEZ, SEN
    } opcode_mnemonic;

    typedef enum logic [1:0] {
        INSTR   = 2'd0,
        SRC_EXT = 2'd1,
        DST_EXT = 2'd2
    } enc_kind_t;

    // How the captured operand fields are merged into the base word
    typedef enum logic [2:0] {
        CLS_DOP, CLS_BR, CLS_SOP, CLS_JSR, CLS_RTS, CLS_JMP, CLS_SWAB, CLS_FIXED
    } op_class_t;

    localparam logic [15:0] OP_BYTE = 16'o100000;
    localparam logic [15:0] OP_MOV  = 16'o010000, OP_CMP  = 16'o020000,
                            OP_BIT  = 16'o030000, OP_BIC  = 16'o040000,
                            OP_BIS  = 16'o050000, OP_ADD  = 16'o060000,
                            OP_SUB  = 16'o160000;
    localparam logic [15:0] OP_BR   = 16'o000400, OP_BNE  = 16'o001000,
                            OP_BEQ  = 16'o001400, OP_BGE  = 16'o002000,
                            OP_BLT  = 16'o002400, OP_BGT  = 16'o003000,
                            OP_BLE  = 16'o003400, OP_BPL  = 16'o100000,
                            OP_BMI  = 16'o100400, OP_BHI  = 16'o101000,
                            OP_BLOS = 16'o101400, OP_BVC  = 16'o102000,
                            OP_BVS  = 16'o102400, OP_BCC  = 16'o103000,
                            OP_BCS  = 16'o103400;
    localparam logic [15:0] OP_CLR  = 16'o005000, OP_COM  = 16'o005100,
                            OP_INC  = 16'o005200, OP_DEC  = 16'o005300,
                            OP_NEG  = 16'o005400, OP_ADC  = 16'o005500,
                            OP_SBC  = 16'o005600, OP_TST  = 16'o005700,
                            OP_ROR  = 16'o006000, OP_ROL  = 16'o006100,
                            OP_ASR  = 16'o006200, OP_ASL  = 16'o006300;
    localparam logic [15:0] OP_JSR  = 16'o004000, OP_RTS  = 16'o000200,
                            OP_JMP  = 16'o000100, OP_SWAB = 16'o000300;
    localparam logic [15:0] OP_HALT = 16'o000000, OP_NOP  = 16'o000240,
                            OP_CLC  = 16'o000241, OP_CLV  = 16'o000242,
                            OP_CLZ  = 16'o000244, OP_CLN  = 16'o000250,
                            OP_SEC  = 16'o000261, OP_SEV  = 16'o000262,
                            OP_SEZ  = 16'o000264, OP_SEN  = 16'o000270;

    // Index/deferred-index modes always carry a word; autoincrement through
    // the PC is immediate (mode 2) or absolute (mode 3) and carries one too.
    function automatic logic need_ext(mode_t mode, reg_t rg);
        return (mode == 3'd6) || (mode == 3'd7) ||
               (((mode == 3'd2) || (mode == 3'd3)) && (rg == 3'd7));
    endfunction

endpackage
`default_nettype wire

// File: rtl/pdp11_inst_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : pdp11_inst_encoder_if
// Purpose  : Request and output-stream handshake bundle of the encoder.
//            master = requester/consumer, slave = encoder.
// Revision : 1.0 - initial release
// ============================================================================
interface pdp11_inst_encoder_if
    import pdp11_inst_encoder_pkg::*;
#(
    parameter int WORD_W = 16
) ();
    logic                in_valid;
    logic                in_ready;
    opcode_mnemonic      in_mnem;
    logic [2:0]          in_smod;
    logic [2:0]          in_sreg;
    logic [2:0]          in_dmod;
    logic [2:0]          in_dreg;
    logic [7:0]          in_ofst;
    logic [15:0]         in_sx;
    logic [15:0]         in_dx;
    logic                out_valid;
    logic                out_ready;
    logic [WORD_W-1:0]   out_word;
    enc_kind_t           out_kind;
    logic                out_last;
    logic                err;

    modport master (
        output in_valid, in_mnem, in_smod, in_sreg, in_dmod, in_dreg,
               in_ofst, in_sx, in_dx, out_ready,
        input  in_ready, out_valid, out_word, out_kind, out_last, err
    );

    modport slave (
        input  in_valid, in_mnem, in_smod, in_sreg, in_dmod, in_dreg,
               in_ofst, in_sx, in_dx, out_ready,
        output in_ready, out_valid, out_word, out_kind, out_last, err
    );
endinterface
`default_nettype wire

// File: rtl/pdp11_opcode_rom.sv
`default_nettype none
// ============================================================================
// Module   : pdp11_opcode_rom
// Purpose  : Combinational map from mnemonic to base word and operand class.
//            known = 0 flags an out-of-range mnemonic value.
// Revision : 1.0 - initial release
// ============================================================================
module pdp11_opcode_rom
    import pdp11_inst_encoder_pkg::*;
(
    input  opcode_mnemonic mnem,
    output logic [15:0]    base,
    output op_class_t      cls,
    output logic           known
);

    // Base word per mnemonic; byte forms set bit 15 on the word form
    always_comb begin
        base  = OP_HALT;
        known = 1'b1;
        case (mnem)
            MOV:  base = OP_MOV;            CMP:  base = OP_CMP;
            BIT:  base = OP_BIT;            BIC:  base = OP_BIC;
            BIS:  base = OP_BIS;            ADD:  base = OP_ADD;
            SUB:  base = OP_SUB;
            MOVB: base = OP_MOV | OP_BYTE;  CMPB: base = OP_CMP | OP_BYTE;
            BITB: base = OP_BIT | OP_BYTE;  BICB: base = OP_BIC | OP_BYTE;
            BISB: base = OP_BIS | OP_BYTE;
            BR:   base = OP_BR;             BNE:  base = OP_BNE;
            BEQ:  base = OP_BEQ;            BGE:  base = OP_BGE;
            BLT:  base = OP_BLT;            BGT:  base = OP_BGT;
            BLE:  base = OP_BLE;            BPL:  base = OP_BPL;
            BMI:  base = OP_BMI;            BHI:  base = OP_BHI;
            BLOS: base = OP_BLOS;           BVC:  base = OP_BVC;
            BVS:  base = OP_BVS;            BCC:  base = OP_BCC;
            BCS:  base = OP_BCS;
            CLR:  base = OP_CLR;            COM:  base = OP_COM;
            INC:  base = OP_INC;            DEC:  base = OP_DEC;
            NEG:  base = OP_NEG;            ADC:  base = OP_ADC;
            SBC:  base = OP_SBC;            TST:  base = OP_TST;
            ROR:  base = OP_ROR;            ROL:  base = OP_ROL;
            ASR:  base = OP_ASR;            ASL:  base = OP_ASL;
            CLRB: base = OP_CLR | OP_BYTE;  COMB: base = OP_COM | OP_BYTE;
            INCB: base = OP_INC | OP_BYTE;  DECB: base = OP_DEC | OP_BYTE;
            NEGB: base = OP_NEG | OP_BYTE;  ADCB: base = OP_ADC | OP_BYTE;
            SBCB: base = OP_SBC | OP_BYTE;  TSTB: base = OP_TST | OP_BYTE;
            RORB: base = OP_ROR | OP_BYTE;  ROLB: base = OP_ROL | OP_BYTE;
            ASRB: base = OP_ASR | OP_BYTE;  ASLB: base = OP_ASL | OP_BYTE;
            JSR:  base = OP_JSR;            RTS:  base = OP_RTS;
            JMP:  base = OP_JMP;            SWAB: base = OP_SWAB;
            HALT: base = OP_HALT;           NOP:  base = OP_NOP;
            CLC:  base = OP_CLC;            CLV:  base = OP_CLV;
            CLZ:  base = OP_CLZ;            CLN:  base = OP_CLN;
            SEC:  base = OP_SEC;            SEV:  base = OP_SEV;
            SEZ:  base = OP_SEZ;            SEN:  base = OP_SEN;
            default: known = 1'b0;
        endcase
    end

    // Operand class selects which fields get merged into the base word
    always_comb begin
        cls = CLS_FIXED;
        case (mnem)
            MOV, CMP, BIT, BIC, BIS, ADD, SUB,
            MOVB, CMPB, BITB, BICB, BISB:                 cls = CLS_DOP;
            BR, BNE, BEQ, BGE, BLT, BGT, BLE,
            BPL, BMI, BHI, BLOS, BVC, BVS, BCC, BCS:      cls = CLS_BR;
            CLR, COM, INC, DEC, NEG, ADC, SBC, TST, ROR, ROL, ASR, ASL,
            CLRB, COMB, INCB, DECB, NEGB, ADCB, SBCB, TSTB,
            RORB, ROLB, ASRB, ASLB:                       cls = CLS_SOP;
            JSR:  cls = CLS_JSR;
            RTS:  cls = CLS_RTS;
            JMP:  cls = CLS_JMP;
            SWAB: cls = CLS_SWAB;
            default: cls = CLS_FIXED;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pdp11_inst_encoder.sv
`default_nettype none
// ============================================================================
// Module   : pdp11_inst_encoder
// Purpose  : Encodes one symbolic PDP-11/20 instruction per request into a
//            1-3 word machine-code stream (instruction, src ext, dst ext).
// Config   : PDP11_ENC_CHECK_EN - reject JMP/JSR with register destination
//            and out-of-range mnemonics, pulsing err instead of encoding.
// Revision : 1.0 - initial release
// ============================================================================
module pdp11_inst_encoder
    import pdp11_inst_encoder_pkg::*;
#(
    parameter int WORD_W         = 16,
    parameter int CHK_FIFO_DEPTH = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    pdp11_inst_encoder_if.slave bus
);

    if (CHK_FIFO_DEPTH != 0) begin : g_no_fifo
        $error("CHK_FIFO_DEPTH is reserved and must be 0");
    end
    if (WORD_W != WORD_SIZE) begin : g_word_w
        $error("WORD_W must equal WORD_SIZE");
    end

    typedef enum logic [1:0] {S_IDLE, S_INSTR, S_SRCX, S_DSTX} state_t;

    state_t      state, next_state;
    logic [15:0] base_word, enc_word;
    op_class_t   op_cls;
    logic        mnem_known;
    logic        accept, illegal, take, out_hs, ext_s, ext_d;
    logic [15:0] cap_word, cap_sx, cap_dx;
    logic        cap_need_s, cap_need_d;

    pdp11_opcode_rom u_rom (
        .mnem  (bus.in_mnem),
        .base  (base_word),
        .cls   (op_cls),
        .known (mnem_known)
    );

    assign accept = bus.in_valid && (state == S_IDLE);
    assign take   = accept && !illegal;
    assign out_hs = bus.out_valid && bus.out_ready;
    assign ext_s  = (op_cls == CLS_DOP) && need_ext(bus.in_smod, bus.in_sreg);
    assign ext_d  = ((op_cls == CLS_DOP) || (op_cls == CLS_SOP) || (op_cls == CLS_JSR) ||
                     (op_cls == CLS_JMP) || (op_cls == CLS_SWAB)) &&
                    need_ext(bus.in_dmod, bus.in_dreg);

`ifdef PDP11_ENC_CHECK_EN
    logic err_q;
    assign illegal = !mnem_known ||
                     (((bus.in_mnem == JMP) || (bus.in_mnem == JSR)) && (bus.in_dmod == 3'd0));
    // One-cycle rejection pulse following an illegal request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) err_q <= 1'b0;
        else          err_q <= accept && illegal;
    end
    assign bus.err = err_q;
`else
    logic unused_known;
    assign unused_known = mnem_known;
    assign illegal      = 1'b0;
    assign bus.err      = 1'b0;
`endif

    // Merge operand fields into the base word; each field is truncated in place
    always_comb begin
        enc_word = base_word;
        case (op_cls)
            CLS_DOP:  enc_word = base_word | {4'b0, bus.in_smod, bus.in_sreg, bus.in_dmod, bus.in_dreg};
            CLS_BR:   enc_word = base_word | {8'b0, bus.in_ofst};
            CLS_SOP, CLS_JMP, CLS_SWAB:
                      enc_word = base_word | {10'b0, bus.in_dmod, bus.in_dreg};
            CLS_JSR:  enc_word = base_word | {7'b0, bus.in_sreg, bus.in_dmod, bus.in_dreg};
            CLS_RTS:  enc_word = base_word | {13'b0, bus.in_dreg};
            default:  enc_word = base_word;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= next_state;
    end

    // Capture the encoded word and extension words on acceptance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_word   <= '0;
            cap_sx     <= '0;
            cap_dx     <= '0;
            cap_need_s <= 1'b0;
            cap_need_d <= 1'b0;
        end else if (take) begin
            cap_word   <= enc_word;
            cap_sx     <= bus.in_sx;
            cap_dx     <= bus.in_dx;
            cap_need_s <= ext_s;
            cap_need_d <= ext_d;
        end
    end

    // Next state and stream outputs; words advance only on handshake
    always_comb begin
        next_state    = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_word  = '0;
        bus.out_kind  = INSTR;
        bus.out_last  = 1'b0;
        case (state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (take) next_state = S_INSTR;
            end
            S_INSTR: begin
                bus.out_valid = 1'b1;
                bus.out_word  = cap_word;
                bus.out_last  = !cap_need_s && !cap_need_d;
                if (out_hs) next_state = cap_need_s ? S_SRCX : (cap_need_d ? S_DSTX : S_IDLE);
            end
            S_SRCX: begin
                bus.out_valid = 1'b1;
                bus.out_word  = cap_sx;
                bus.out_kind  = SRC_EXT;
                bus.out_last  = !cap_need_d;
                if (out_hs) next_state = cap_need_d ? S_DSTX : S_IDLE;
            end
            S_DSTX: begin
                bus.out_valid = 1'b1;
                bus.out_word  = cap_dx;
                bus.out_kind  = DST_EXT;
                bus.out_last  = 1'b1;
                if (out_hs) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_pdp11_inst_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pdp11_inst_encoder
// Purpose  : Scoreboard bench for pdp11_inst_encoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pdp11_inst_encoder;
    import pdp11_inst_encoder_pkg::*;

    typedef struct packed {
        logic [15:0] word;
        logic [1:0]  kind;
        logic        last;
    } exp_t;

    logic clk;
    logic reset_n;
    int   n_chk = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    pdp11_inst_encoder_if #(.WORD_W(16)) bus ();

    pdp11_inst_encoder #(.WORD_W(16), .CHK_FIFO_DEPTH(0)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0o expected %0o", tag, got, exp);
        end
    endtask

    function automatic void expect_word(input logic [15:0] w, input enc_kind_t k, input logic l);
        exp_t e;
        e.word = w;
        e.kind = k;
        e.last = l;
        exp_q.push_back(e);
    endfunction

    // Output monitor: every handshaken word is compared with the scoreboard head
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", 32'(bus.out_word), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("word", 32'(bus.out_word), 32'(e.word));
                check("kind", 32'(bus.out_kind), 32'(e.kind));
                check("last", 32'(bus.out_last), 32'(e.last));
            end
        end
    end

    task automatic send(input opcode_mnemonic m, input logic [2:0] sm, input logic [2:0] sr,
                        input logic [2:0] dm, input logic [2:0] dr, input logic [7:0] of,
                        input logic [15:0] sx, input logic [15:0] dx, input logic exp_out);
        bit ok;
        ok = 1'b0;
        bus.in_mnem = m;   bus.in_smod = sm;  bus.in_sreg = sr;
        bus.in_dmod = dm;  bus.in_dreg = dr;  bus.in_ofst = of;
        bus.in_sx   = sx;  bus.in_dx   = dx;  bus.in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept_timeout", 32'(ok), 32'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        check("latency_valid", 32'(bus.out_valid), 32'(exp_out));
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
        check("drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_mnem   = HALT;
        bus.in_smod   = 3'd0; bus.in_sreg = 3'd0;
        bus.in_dmod   = 3'd0; bus.in_dreg = 3'd0;
        bus.in_ofst   = 8'd0; bus.in_sx   = 16'd0; bus.in_dx = 16'd0;
        bus.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_word",  32'(bus.out_word),  32'd0);
        check("rst_out_kind",  32'(bus.out_kind),  32'd0);
        check("rst_out_last",  32'(bus.out_last),  32'd0);
        check("rst_err",       32'(bus.err),       32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // MOV #5,R1
        expect_word(16'o012701, INSTR, 1'b0);
        expect_word(16'o000005, SRC_EXT, 1'b1);
        send(MOV, 3'd2, 3'd7, 3'd0, 3'd1, 8'd0, 16'o000005, 16'd0, 1'b1);
        // ADD @#100,6(R3)
        expect_word(16'o063763, INSTR, 1'b0);
        expect_word(16'o000100, SRC_EXT, 1'b0);
        expect_word(16'o000006, DST_EXT, 1'b1);
        send(ADD, 3'd3, 3'd7, 3'd6, 3'd3, 8'd0, 16'o000100, 16'o000006, 1'b1);
        // BNE .-2 words, SEC, RTS R5, MOVB R1,R2
        expect_word(16'o001376, INSTR, 1'b1);
        send(BNE, 3'd0, 3'd0, 3'd0, 3'd0, 8'hFE, 16'd0, 16'd0, 1'b1);
        expect_word(16'o000261, INSTR, 1'b1);
        send(SEC, 3'd0, 3'd0, 3'd0, 3'd0, 8'd0, 16'd0, 16'd0, 1'b1);
        expect_word(16'o000205, INSTR, 1'b1);
        send(RTS, 3'd0, 3'd0, 3'd0, 3'd5, 8'd0, 16'd0, 16'd0, 1'b1);
        expect_word(16'o110102, INSTR, 1'b1);
        send(MOVB, 3'd0, 3'd1, 3'd0, 3'd2, 8'd0, 16'd0, 16'd0, 1'b1);
        // JSR PC,@#200: source pair looks like immediate but must not add a word
        expect_word(16'o004737, INSTR, 1'b0);
        expect_word(16'o000200, DST_EXT, 1'b1);
        send(JSR, 3'd2, 3'd7, 3'd3, 3'd7, 8'd0, 16'o111111, 16'o000200, 1'b1);
        // TSTB (R1)+ and BR with the offset sign bit set
        expect_word(16'o105721, INSTR, 1'b1);
        send(TSTB, 3'd0, 3'd0, 3'd2, 3'd1, 8'd0, 16'd0, 16'd0, 1'b1);
        expect_word(16'o000600, INSTR, 1'b1);
        send(BR, 3'd0, 3'd0, 3'd0, 3'd0, 8'h80, 16'd0, 16'd0, 1'b1);
        drain();

        // Backpressure while the source extension word is pending
        expect_word(16'o012701, INSTR, 1'b0);
        expect_word(16'o000005, SRC_EXT, 1'b1);
        send(MOV, 3'd2, 3'd7, 3'd0, 3'd1, 8'd0, 16'o000005, 16'd0, 1'b1);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.in_mnem = SEC; bus.in_smod = 3'd0; bus.in_sreg = 3'd0;
        bus.in_dmod = 3'd0; bus.in_dreg = 3'd0; bus.in_valid = 1'b1;
        expect_word(16'o000261, INSTR, 1'b1);
        repeat (5) begin
            @(negedge clk);
            check("bp_valid",    32'(bus.out_valid), 32'd1);
            check("bp_word",     32'(bus.out_word),  32'o000005);
            check("bp_kind",     32'(bus.out_kind),  32'd1);
            check("bp_in_ready", 32'(bus.in_ready),  32'd0);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        begin
            bit ok;
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (bus.in_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            check("bp_accept_timeout", 32'(ok), 32'd1);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        drain();

        // Reset in DSTX aborts the remaining word
        expect_word(16'o063763, INSTR, 1'b0);
        expect_word(16'o000100, SRC_EXT, 1'b0);
        send(ADD, 3'd3, 3'd7, 3'd6, 3'd3, 8'd0, 16'o000100, 16'o000006, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("dstx_kind", 32'(bus.out_kind), 32'd2);
        check("dstx_word", 32'(bus.out_word), 32'o000006);
        reset_n = 1'b0;
        #1;
        check("abort_valid",    32'(bus.out_valid), 32'd0);
        check("abort_in_ready", 32'(bus.in_ready),  32'd1);
        check("abort_word",     32'(bus.out_word),  32'd0);
        check("abort_last",     32'(bus.out_last),  32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        check("abort_queue", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
        expect_word(16'o000261, INSTR, 1'b1);
        send(SEC, 3'd0, 3'd0, 3'd0, 3'd0, 8'd0, 16'd0, 16'd0, 1'b1);
        drain();

        // JMP R0: illegal with checking enabled, encoded verbatim otherwise
`ifdef PDP11_ENC_CHECK_EN
        send(JMP, 3'd0, 3'd0, 3'd0, 3'd0, 8'd0, 16'd0, 16'd0, 1'b0);
        check("jmp_err_pulse", 32'(bus.err), 32'd1);
        @(negedge clk);
        check("jmp_err_clear", 32'(bus.err), 32'd0);
        check("jmp_no_valid",  32'(bus.out_valid), 32'd0);
        send(opcode_mnemonic'(7'd100), 3'd0, 3'd0, 3'd1, 3'd0, 8'd0, 16'd0, 16'd0, 1'b0);
        check("oor_err_pulse", 32'(bus.err), 32'd1);
        @(negedge clk);
        check("oor_no_valid",  32'(bus.out_valid), 32'd0);
`else
        expect_word(16'o000100, INSTR, 1'b1);
        send(JMP, 3'd0, 3'd0, 3'd0, 3'd0, 8'd0, 16'd0, 16'd0, 1'b1);
        check("jmp_no_err", 32'(bus.err), 32'd0);
`endif
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
